// File: rtl/rotary_decoder.sv
// Quadrature decoder for a debounced rotary encoder: detent step pulses with direction,
// a bounded position counter, a centre-press pulse and an illegal-transition flag.
module rotary_decoder #(
   parameter int          WIDTH       = 8,
   parameter int unsigned RESET_COUNT = 0,
   parameter bit          WRAP        = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rotA,
   input  logic             rotB,
   input  logic             rotCTR,
   output logic             step,
   output logic             dir,
   output logic [WIDTH-1:0] count,
   output logic             press,
   output logic             err
);

   localparam logic [WIDTH-1:0] LP_RESET = WIDTH'(RESET_COUNT);
   localparam logic [WIDTH-1:0] LP_ONE   = WIDTH'(1);
   localparam logic [WIDTH-1:0] LP_MAX   = '1;
   localparam logic [WIDTH-1:0] LP_MIN   = '0;

   logic [1:0]        r_ab_q;
   logic              r_ctr_q;
   logic              r_primed;
   logic signed [3:0] r_acc;
   logic              r_step;
   logic              r_dir;
   logic [WIDTH-1:0]  r_count;
   logic              r_press;
   logic              r_err;

   logic [1:0]        w_ab;
   logic              w_changed;
   logic              w_illegal;
   logic              w_cw;
   logic signed [3:0] w_acc_next;
   logic              w_cw_done;
   logic              w_ccw_done;
   logic [WIDTH-1:0]  w_count_inc;
   logic [WIDTH-1:0]  w_count_dec;

   assign w_ab      = {rotA, rotB};
   assign w_changed = (w_ab != r_ab_q);
   assign w_illegal = ((w_ab ^ r_ab_q) == 2'b11);

   // Clockwise Gray steps: 00->01->11->10->00; any other single-bit change is CCW.
   always_comb begin
      w_cw = 1'b0;
      case ({r_ab_q, w_ab})
         4'b0001, 4'b0111, 4'b1110, 4'b1000: w_cw = 1'b1;
         default:                            w_cw = 1'b0;
      endcase
   end

   always_comb begin
      w_acc_next = r_acc;
      if (w_cw) begin
         if (r_acc != 4'sd4) w_acc_next = r_acc + 4'sd1;
      end else begin
         if (r_acc != -4'sd4) w_acc_next = r_acc - 4'sd1;
      end
   end

   assign w_cw_done  = w_changed & ~w_illegal & (w_ab == 2'b00) & (w_acc_next == 4'sd4);
   assign w_ccw_done = w_changed & ~w_illegal & (w_ab == 2'b00) & (w_acc_next == -4'sd4);

   assign w_count_inc = (WRAP || (r_count != LP_MAX)) ? r_count + LP_ONE : r_count;
   assign w_count_dec = (WRAP || (r_count != LP_MIN)) ? r_count - LP_ONE : r_count;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ab_q   <= 2'b00;
         r_ctr_q  <= 1'b0;
         r_primed <= 1'b0;
         r_acc    <= 4'sd0;
         r_step   <= 1'b0;
         r_dir    <= 1'b0;
         r_count  <= LP_RESET;
         r_press  <= 1'b0;
         r_err    <= 1'b0;
      end else if (!r_primed) begin
         // Resynchronise to the resting encoder position; nothing is decoded this cycle.
         r_primed <= 1'b1;
         r_ab_q   <= w_ab;
         r_ctr_q  <= rotCTR;
         r_step   <= 1'b0;
         r_press  <= 1'b0;
         r_err    <= 1'b0;
      end else begin
         r_ctr_q <= rotCTR;
         r_press <= rotCTR & ~r_ctr_q;
         r_step  <= w_cw_done | w_ccw_done;
         r_err   <= w_changed & w_illegal;
         if (w_changed) begin
            r_ab_q <= w_ab;
            if (w_illegal || (w_ab == 2'b00)) r_acc <= 4'sd0;
            else                              r_acc <= w_acc_next;
         end
         if (w_cw_done) begin
            r_dir   <= 1'b1;
            r_count <= w_count_inc;
         end else if (w_ccw_done) begin
            r_dir   <= 1'b0;
            r_count <= w_count_dec;
         end
      end
   end

   assign step  = r_step;
   assign dir   = r_dir;
   assign count = r_count;
   assign press = r_press;
   assign err   = r_err;

endmodule

// File: tb/tb_rotary_decoder.sv
// Bench for rotary_decoder: directed scenarios then a random walk, both checked against
// a phase-arithmetic model of a wrapping (0 reset) and a saturating (255 reset) decoder.
module tb_rotary_decoder;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rotA = 1'b0;
   logic       rotB = 1'b0;
   logic       rotCTR = 1'b0;

   logic       step0, dir0, press0, err0;
   logic [7:0] count0;
   logic       step1, dir1, press1, err1;
   logic [7:0] count1;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   rotary_decoder #(.WIDTH(8), .RESET_COUNT(0), .WRAP(1'b1)) u_wrap (
      .clk(clk), .reset(reset), .rotA(rotA), .rotB(rotB), .rotCTR(rotCTR),
      .step(step0), .dir(dir0), .count(count0), .press(press0), .err(err0)
   );

   rotary_decoder #(.WIDTH(8), .RESET_COUNT(255), .WRAP(1'b0)) u_sat (
      .clk(clk), .reset(reset), .rotA(rotA), .rotB(rotB), .rotCTR(rotCTR),
      .step(step1), .dir(dir1), .count(count1), .press(press1), .err(err1)
   );

   // Reference model state
   int m_abq, m_ctrq, m_acc, m_primed;
   int m_cnt0, m_cnt1;
   int m_dir, e_step, e_press, e_err;

   // Position of an AB code around the CW cycle 00,01,11,10
   function automatic int phase(input int ab);
      case (ab)
         0:       return 0;
         1:       return 1;
         3:       return 2;
         default: return 3;
      endcase
   endfunction

   function automatic int code_of(input int ph);
      case (ph)
         0:       return 0;
         1:       return 1;
         2:       return 3;
         default: return 2;
      endcase
   endfunction

   task automatic model(input int ab, input int ctr, input int rst);
      int d;
      if (rst != 0) begin
         m_abq = 0; m_ctrq = 0; m_acc = 0; m_primed = 0;
         m_cnt0 = 0; m_cnt1 = 255; m_dir = 0;
         e_step = 0; e_press = 0; e_err = 0;
      end else if (m_primed == 0) begin
         m_abq = ab; m_ctrq = ctr; m_primed = 1;
         e_step = 0; e_press = 0; e_err = 0;
      end else begin
         e_press = (ctr == 1 && m_ctrq == 0) ? 1 : 0;
         m_ctrq = ctr;
         e_step = 0;
         e_err = 0;
         if (ab != m_abq) begin
            d = (phase(ab) - phase(m_abq) + 4) % 4;
            if (d == 2) begin
               e_err = 1;
               m_acc = 0;
            end else begin
               m_acc = m_acc + ((d == 1) ? 1 : -1);
               if (m_acc > 4) m_acc = 4;
               if (m_acc < -4) m_acc = -4;
               if (ab == 0) begin
                  if (m_acc == 4) begin
                     e_step = 1; m_dir = 1;
                     m_cnt0 = (m_cnt0 + 1) % 256;
                     if (m_cnt1 < 255) m_cnt1 = m_cnt1 + 1;
                  end else if (m_acc == -4) begin
                     e_step = 1; m_dir = 0;
                     m_cnt0 = (m_cnt0 + 255) % 256;
                     if (m_cnt1 > 0) m_cnt1 = m_cnt1 - 1;
                  end
                  m_acc = 0;
               end
            end
            m_abq = ab;
         end
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int ab, input int ctr, input int rst);
      rotA   = ab[1];
      rotB   = ab[0];
      rotCTR = ctr[0];
      reset  = rst[0];
      @(posedge clk);
      model(ab, ctr, rst);
      #1;
      chk("wrap.step",  32'(step0),  32'(e_step));
      chk("wrap.dir",   32'(dir0),   32'(m_dir));
      chk("wrap.count", 32'(count0), 32'(m_cnt0));
      chk("wrap.press", 32'(press0), 32'(e_press));
      chk("wrap.err",   32'(err0),   32'(e_err));
      chk("sat.step",   32'(step1),  32'(e_step));
      chk("sat.dir",    32'(dir1),   32'(m_dir));
      chk("sat.count",  32'(count1), 32'(m_cnt1));
      chk("sat.press",  32'(press1), 32'(e_press));
      chk("sat.err",    32'(err1),   32'(e_err));
   endtask

   task automatic hold(input int ab, input int ctr, input int n);
      for (int i = 0; i < n; i++) cyc(ab, ctr, 0);
   endtask

   int cur_ab, cur_ctr, rdir, r, rst;

   initial begin
      // Reset values
      cyc(0, 0, 1);
      cyc(0, 0, 1);
      chk("rst.count_wrap", 32'(count0), 0);
      chk("rst.count_sat",  32'(count1), 255);
      cyc(0, 0, 0);

      // CW detent
      hold(1, 0, 3); hold(3, 0, 3); hold(2, 0, 3);
      cyc(0, 0, 0);
      chk("cw.step", 32'(step0), 1);
      chk("cw.dir",  32'(dir0), 1);
      chk("cw.count", 32'(count0), 1);
      chk("cw.sat_hold", 32'(count1), 255);
      cyc(0, 0, 0);
      chk("cw.step_one_cycle", 32'(step0), 0);

      // CCW detents: 1 -> 0 -> 255 wrap; 255 -> 254 -> 253 saturating counter
      hold(2, 0, 3); hold(3, 0, 3); hold(1, 0, 3); hold(0, 0, 3);
      chk("ccw1.count_sat", 32'(count1), 254);
      hold(2, 0, 2); hold(3, 0, 2); hold(1, 0, 2);
      cyc(0, 0, 0);
      chk("ccw.step", 32'(step0), 1);
      chk("ccw.dir",  32'(dir0), 0);
      chk("ccw.wrap", 32'(count0), 255);
      hold(0, 0, 2);

      // Reversal then illegal jump
      hold(1, 0, 2);
      cyc(0, 0, 0);
      chk("rev.no_step", 32'(step0), 0);
      chk("rev.count", 32'(count0), 255);
      cyc(3, 0, 0);
      chk("ill.err", 32'(err0), 1);
      chk("ill.no_step", 32'(step0), 0);
      cyc(3, 0, 0);
      chk("ill.err_one_cycle", 32'(err0), 0);
      hold(0, 0, 2);

      // Press, then press coinciding with detent completion
      cyc(0, 1, 0);
      chk("press.pulse", 32'(press0), 1);
      hold(0, 1, 9);
      hold(0, 0, 2);
      hold(1, 0, 2); hold(3, 0, 2); hold(2, 0, 2);
      cyc(0, 1, 0);
      chk("press.with_step.press", 32'(press0), 1);
      chk("press.with_step.step",  32'(step0), 1);
      hold(0, 0, 2);

      // Reset mid-rotation with the encoder left at 11
      hold(1, 0, 2); hold(3, 0, 2);
      cyc(3, 0, 1); cyc(3, 0, 1);
      cyc(3, 0, 0);
      chk("rmid.prime_no_err", 32'(err0), 0);
      hold(2, 0, 2);
      cyc(0, 0, 0);
      chk("rmid.no_step", 32'(step0), 0);
      chk("rmid.count", 32'(count0), 0);
      hold(0, 0, 2);
      hold(1, 0, 2); hold(3, 0, 2); hold(2, 0, 2); hold(0, 0, 2);
      chk("rmid.cw_after", 32'(count0), 1);

      // Random walk with holds, direction changes, illegal jumps, presses and resets
      cur_ab = 0; cur_ctr = 0; rdir = 1;
      for (int i = 0; i < 3000; i++) begin
         r = int'($urandom_range(0, 99));
         if (r >= 40 && r < 94)
            cur_ab = code_of((phase(cur_ab) + ((rdir != 0) ? 1 : 3)) % 4);
         else if (r >= 94)
            cur_ab = cur_ab ^ 3;
         if ($urandom_range(0, 24) == 0) rdir = (rdir != 0) ? 0 : 1;
         if ($urandom_range(0, 9) == 0) cur_ctr = (cur_ctr != 0) ? 0 : 1;
         rst = ($urandom_range(0, 299) == 0) ? 1 : 0;
         cyc(cur_ab, cur_ctr, rst);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
